// File: rtl/riscv_rf_wrarb.sv
`default_nettype none
// ============================================================================
// Module   : riscv_rf_wrarb
// Purpose  : Register-file write arbiter for the debug unit, writeback and a
//            FIFO of late load returns, with starvation escape and hazard flags.
// Revision : 1.0 - initial release
// ============================================================================
module riscv_rf_wrarb #(
    parameter int XLEN   = 32,
    parameter int DEPTH  = 2,
    parameter int STARVE = 4
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [4:0]      wb_dst_i,
    input  logic [XLEN-1:0] wb_d_i,
    input  logic            wb_we_i,
    output logic            wb_stall_o,
    input  logic [4:0]      lsu_dst_i,
    input  logic [XLEN-1:0] lsu_d_i,
    input  logic            lsu_valid_i,
    output logic            lsu_ready_o,
    input  logic            du_we_rf_i,
    input  logic [11:0]     du_addr_i,
    input  logic [XLEN-1:0] du_d_i,
    input  logic [4:0]      rd_src1_i,
    input  logic [4:0]      rd_src2_i,
    output logic            src1_pend_o,
    output logic            src2_pend_o,
    output logic [4:0]      rf_dst_o,
    output logic [XLEN-1:0] rf_dst_d_o,
    output logic            rf_we_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(STARVE + 1);

    localparam logic [CW-1:0] c_starve   = CW'(STARVE);
    localparam logic [1:0]    c_src_none = 2'd0;
    localparam logic [1:0]    c_src_du   = 2'd1;
    localparam logic [1:0]    c_src_fifo = 2'd2;
    localparam logic [1:0]    c_src_wb   = 2'd3;

    logic [4:0]      r_fifo_dst [DEPTH];
    logic [XLEN-1:0] r_fifo_d   [DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_starve_cnt;
    logic            r_rf_we;
    logic [4:0]      r_rf_dst;
    logic [XLEN-1:0] r_rf_d;

    logic [PW-1:0]   w_count;
    logic            w_empty;
    logic            w_full;
    logic            w_starved;
    logic            w_enq;
    logic            w_deq;
    logic [1:0]      w_sel;
    logic [4:0]      w_gnt_dst;
    logic [XLEN-1:0] w_gnt_d;
    logic [DEPTH-1:0] w_hit1;
    logic [DEPTH-1:0] w_hit2;
    logic [6:0]      w_unused_addr;

    assign w_unused_addr = du_addr_i[11:5];

    assign w_count   = r_wr_ptr - r_rd_ptr;
    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_starved = (r_starve_cnt == c_starve);
    assign w_enq     = lsu_valid_i && !w_full;
    assign w_deq     = (w_sel == c_src_fifo);

    // Fixed priority: debug, starved head, writeback, head.
    always_comb begin
        w_sel     = c_src_none;
        w_gnt_dst = '0;
        w_gnt_d   = '0;
        if (du_we_rf_i) begin
            w_sel     = c_src_du;
            w_gnt_dst = du_addr_i[4:0];
            w_gnt_d   = du_d_i;
        end else if (!w_empty && w_starved) begin
            w_sel     = c_src_fifo;
            w_gnt_dst = r_fifo_dst[r_rd_ptr[AW-1:0]];
            w_gnt_d   = r_fifo_d[r_rd_ptr[AW-1:0]];
        end else if (wb_we_i) begin
            w_sel     = c_src_wb;
            w_gnt_dst = wb_dst_i;
            w_gnt_d   = wb_d_i;
        end else if (!w_empty) begin
            w_sel     = c_src_fifo;
            w_gnt_dst = r_fifo_dst[r_rd_ptr[AW-1:0]];
            w_gnt_d   = r_fifo_d[r_rd_ptr[AW-1:0]];
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_enq) begin
            r_fifo_dst[r_wr_ptr[AW-1:0]] <= lsu_dst_i;
            r_fifo_d[r_wr_ptr[AW-1:0]]   <= lsu_d_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_starve_cnt <= '0;
            r_rf_we      <= 1'b0;
            r_rf_dst     <= '0;
            r_rf_d       <= '0;
        end else begin
            if (w_enq) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_deq) r_rd_ptr <= r_rd_ptr + 1'b1;

            if (w_empty || w_deq) begin
                r_starve_cnt <= '0;
            end else if (!w_starved) begin
                r_starve_cnt <= r_starve_cnt + 1'b1;
            end

            // x0 grants are consumed but never reach the register file.
            r_rf_we <= (w_sel != c_src_none) && (w_gnt_dst != 5'd0);
            if (w_sel != c_src_none) begin
                r_rf_dst <= w_gnt_dst;
                r_rf_d   <= w_gnt_d;
            end
        end
    end

    // An entry is live when its distance from the read pointer is below the fill count.
    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        logic [AW-1:0] w_off;
        logic          w_live;
        assign w_off     = AW'(i) - r_rd_ptr[AW-1:0];
        assign w_live    = ({1'b0, w_off} < w_count);
        assign w_hit1[i] = w_live && (r_fifo_dst[i] == rd_src1_i);
        assign w_hit2[i] = w_live && (r_fifo_dst[i] == rd_src2_i);
    end

    assign src1_pend_o = (rd_src1_i != 5'd0) &&
                         ((|w_hit1) || (r_rf_we && (r_rf_dst == rd_src1_i)));
    assign src2_pend_o = (rd_src2_i != 5'd0) &&
                         ((|w_hit2) || (r_rf_we && (r_rf_dst == rd_src2_i)));

    assign wb_stall_o  = wb_we_i && (du_we_rf_i || w_starved);
    assign lsu_ready_o = !w_full;
    assign rf_we_o     = r_rf_we;
    assign rf_dst_o    = r_rf_dst;
    assign rf_dst_d_o  = r_rf_d;

endmodule
`default_nettype wire

// File: doc/riscv_rf_wrarb.md
RISCV_RF_WRARB -- requirements
Module: riscv_rf_wrarb

Interface
REQ-001 Parameter XLEN, default 32, data width of the register file.
REQ-002 Parameter DEPTH, default 2, number of entries in the LSU write-return FIFO (power of 2, at least 2).
REQ-003 Parameter STARVE, default 4, number of waiting cycles after which the FIFO head is treated as starved.
REQ-004 One clock, clk_i; reset rst_ni is asynchronous and active-low.
REQ-005 clk_i  in  1  clock.
REQ-006 rst_ni  in  1  asynchronous active-low reset.
REQ-007 wb_dst_i  in  5  writeback destination register.
REQ-008 wb_d_i  in  XLEN  writeback data.
REQ-009 wb_we_i  in  1  writeback write request.
REQ-010 wb_stall_o  out  1  writeback not granted this cycle; the requester holds its request.
REQ-011 lsu_dst_i  in  5  late load-return destination register.
REQ-012 lsu_d_i  in  XLEN  late load-return data.
REQ-013 lsu_valid_i  in  1  load-return valid.
REQ-014 lsu_ready_o  out  1  FIFO can accept a load return.
REQ-015 du_we_rf_i  in  1  debug unit register-file write.
REQ-016 du_addr_i  in  12  debug address; bits [4:0] select the register.
REQ-017 du_d_i  in  XLEN  debug write data.
REQ-018 rd_src1_i, rd_src2_i  in  5 each  source registers of the decode stage.
REQ-019 src1_pend_o, src2_pend_o  out  1 each  source has a write that is not yet committed.
REQ-020 rf_dst_o  out  5  register-file write address.
REQ-021 rf_dst_d_o  out  XLEN  register-file write data.
REQ-022 rf_we_o  out  1  register-file write enable.

Function
REQ-023 LSU writes are enqueued on lsu_valid_i & lsu_ready_o, in order.
REQ-024 lsu_ready_o = !full; it is independent of lsu_valid_i and of a same-cycle dequeue.
- When the FIFO is full, no enqueue occurs even if the head is being dequeued.
REQ-025 Each cycle exactly one source is granted, in this priority order:
- 1. du_we_rf_i.
- 2. FIFO head, if starved.
- 3. wb_we_i.
- 4. FIFO head, if non-empty.
REQ-026 The granted destination and data are registered into rf_dst_o and rf_dst_d_o. rf_we_o is 1 in the next cycle, giving a latency of exactly 1 cycle.
REQ-027 rf_we_o is 0 in any cycle following a cycle with no grant.
REQ-028 A grant whose destination is x0 is consumed: the FIFO dequeues, or WB is not stalled. rf_we_o stays 0 for it.
REQ-029 wb_stall_o = wb_we_i & (du_we_rf_i | starved). It is combinational.
REQ-030 The FIFO head is dequeued in the cycle it is granted.
REQ-031 The starve counter:
- Increments each cycle the FIFO is non-empty and the head is not granted.
- Clears on a head grant or when the FIFO is empty.
- Saturates at STARVE.
- starved = (count == STARVE).
REQ-032 srcN_pend_o is 1 when rd_srcN_i is non-zero and matches either:
- the dst of any valid FIFO entry, or
- rf_dst_o while rf_we_o = 1.
- It is combinational.
REQ-033 No ordering is enforced between WB and LSU writes to the same register; decode uses the pend outputs to avoid this case.
REQ-034 FIFO read and write pointers wrap modulo DEPTH. Full and empty are distinguished by an extra pointer bit.

Reset
REQ-035 While rst_ni = 0, the following hold asynchronously:
- rf_we_o = 0, rf_dst_o = 0, rf_dst_d_o = 0.
- FIFO empty, pointers 0, starve counter 0.
- lsu_ready_o = 1.
REQ-036 On reset mid-operation, queued entries are discarded without being written.
REQ-037 Combinational outputs follow REQ-024, REQ-029 and REQ-032 with the reset state.

Verification
REQ-038 WB only: wb_we_i = 1, wb_dst_i = 5, wb_d_i = 0x1234 -> next cycle rf_we_o = 1, rf_dst_o = 5, rf_dst_d_o = 0x1234; wb_stall_o = 0.
REQ-039 DU versus WB in the same cycle: du_addr_i = 0x007, du_d_i = 0xAA, wb_we_i = 1 -> wb_stall_o = 1, next rf_dst_o = 7 with data 0xAA; the cycle after, the WB write commits.
REQ-040 Starvation: one LSU entry (dst 9) with wb_we_i held at 1 continuously -> WB wins 4 cycles, then the head commits (rf_dst_o = 9) and wb_stall_o = 1 for that one cycle.
REQ-041 Full FIFO: DEPTH + 1 back-to-back LSU valids while WB is busy -> lsu_ready_o = 0 after 2 enqueues; the third is held until a dequeue, with no loss and in-order commit.
REQ-042 Hazard: LSU entry dst 3 queued, rd_src1_i = 3 -> src1_pend_o = 1 until one cycle after commit; rd_src2_i = 0 -> src2_pend_o = 0; an x0 write produces no rf_we_o.
REQ-043 Reset asserted with 2 entries queued -> rf_we_o = 0 immediately and lsu_ready_o = 1; after release, no stale writes occur.
